// File: rtl/nco_tune_ctrl.sv
// Tuning sequencer for the receiver NCO: slew-limited direct retunes plus an
// automatic start/stop/step/dwell band scan with carrier-detect hold.
module nco_tune_ctrl #(
  parameter int DWELL_W = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tune_valid,
  output logic               tune_ready,
  input  logic [31:0]        tune_word,
  input  logic [31:0]        slew_step,
  input  logic               scan_en,
  input  logic [31:0]        scan_start,
  input  logic [31:0]        scan_stop,
  input  logic [31:0]        scan_step,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               hold,
  output logic [31:0]        phase_inc,
  output logic               settled,
  output logic               retune_pulse
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SLEW  = 2'd1;
  localparam logic [1:0] DWELL = 2'd2;

  logic [1:0]         state;
  logic [31:0]        target;
  logic               scan_mode;
  logic [DWELL_W-1:0] cnt;

  logic               up;
  logic [31:0]        diff;
  logic [32:0]        next_ch;
  logic [DWELL_W-1:0] dwell_load;
  logic               last_step;

  always_comb begin
    up         = (target >= phase_inc);
    diff       = up ? (target - phase_inc) : (phase_inc - target);
    // carry out of the 33-bit add means the next channel is past the top of the band
    next_ch    = {1'b0, phase_inc} + {1'b0, scan_step};
    dwell_load = (dwell == '0) ? DWELL_W'(1) : dwell;
    last_step  = (slew_step == 32'd0) || (diff <= slew_step);
  end

  assign tune_ready = (state == IDLE) && !scan_en;
  assign settled    = (state != SLEW);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      phase_inc    <= 32'd0;
      target       <= 32'd0;
      scan_mode    <= 1'b0;
      cnt          <= '0;
      retune_pulse <= 1'b0;
    end else begin
      retune_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (scan_en) begin
            target    <= scan_start;
            scan_mode <= 1'b1;
            state     <= SLEW;
          end else if (tune_valid && tune_ready) begin
            target <= tune_word;
            state  <= SLEW;
          end
        end
        SLEW: begin
          if (last_step) begin
            phase_inc    <= target;
            retune_pulse <= 1'b1;
            // a scan dropped mid-slew finishes the slew, then parks in IDLE
            if (scan_mode && scan_en) begin
              state <= DWELL;
              cnt   <= dwell_load;
            end else begin
              state     <= IDLE;
              scan_mode <= 1'b0;
            end
          end else if (up) begin
            phase_inc <= phase_inc + slew_step;
          end else begin
            phase_inc <= phase_inc - slew_step;
          end
        end
        DWELL: begin
          if (!scan_en) begin
            state     <= IDLE;
            scan_mode <= 1'b0;
          end else if (!hold) begin
            if (cnt > DWELL_W'(1)) begin
              cnt <= cnt - DWELL_W'(1);
            end else begin
              if (next_ch[32] || (next_ch[31:0] > scan_stop))
                target <= scan_start;
              else
                target <= next_ch[31:0];
              state <= SLEW;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nco_tune_ctrl.sv
// Bench for nco_tune_ctrl: table of direct retunes plus hand-written scan,
// hold, carry-wrap and gating sequences; retune pulses checked via scoreboard.
module tb_nco_tune_ctrl;
  localparam int DWELL_W = 24;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               tune_valid = 1'b0;
  logic               tune_ready;
  logic [31:0]        tune_word = 32'd0;
  logic [31:0]        slew_step = 32'd0;
  logic               scan_en = 1'b0;
  logic [31:0]        scan_start = 32'd0;
  logic [31:0]        scan_stop = 32'd0;
  logic [31:0]        scan_step = 32'd0;
  logic [DWELL_W-1:0] dwell = '0;
  logic               hold = 1'b0;
  logic [31:0]        phase_inc;
  logic               settled;
  logic               retune_pulse;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];

  nco_tune_ctrl #(.DWELL_W(DWELL_W)) dut (
    .clk(clk), .reset(reset), .tune_valid(tune_valid), .tune_ready(tune_ready),
    .tune_word(tune_word), .slew_step(slew_step), .scan_en(scan_en),
    .scan_start(scan_start), .scan_stop(scan_stop), .scan_step(scan_step),
    .dwell(dwell), .hold(hold), .phase_inc(phase_inc), .settled(settled),
    .retune_pulse(retune_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic [31:0] step;
    int          ncyc;
    logic [31:0] trace[4];
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_vec(input int i, input logic [31:0] w, input logic [31:0] s, input int n,
                         input logic [31:0] t0, input logic [31:0] t1, input logic [31:0] t2);
    vecs[i].word = w;
    vecs[i].step = s;
    vecs[i].ncyc = n;
    vecs[i].trace[0] = t0;
    vecs[i].trace[1] = t1;
    vecs[i].trace[2] = t2;
    vecs[i].trace[3] = 32'd0;
  endtask

  task automatic wait_pulse(input string name, input logic [31:0] val);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(retune_pulse && phase_inc == val) && n < 200);
    chk(name, 32'(retune_pulse && phase_inc == val), 32'd1);
  endtask

  // every completed retune must land on the next expected value
  always @(negedge clk) begin
    if (!reset && retune_pulse) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_pulse: phase_inc 0x%08h with no expected entry", phase_inc);
      end else begin
        chk("sb_phase_inc", phase_inc, sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] obs[4];
    logic [31:0] chan[4];
    int n;

    set_vec(0, 32'h0A3D70A4, 32'd0,        1, 32'h0A3D70A4, 32'd0, 32'd0);
    set_vec(1, 32'h00000000, 32'd0,        1, 32'h00000000, 32'd0, 32'd0);
    set_vec(2, 32'h00050000, 32'h00020000, 3, 32'h00020000, 32'h00040000, 32'h00050000);
    set_vec(3, 32'h00010000, 32'h00020000, 2, 32'h00030000, 32'h00010000, 32'd0);
    set_vec(4, 32'h00010000, 32'h00020000, 1, 32'h00010000, 32'd0, 32'd0);
    set_vec(5, 32'hFFFFFFFF, 32'h80000000, 2, 32'h80010000, 32'hFFFFFFFF, 32'd0);
    set_vec(6, 32'h00000000, 32'hC0000000, 2, 32'h3FFFFFFF, 32'h00000000, 32'd0);

    // power-on reset
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_phase_inc", phase_inc, 32'd0);
    chk("rst_settled", 32'(settled), 32'd1);
    chk("rst_tune_ready", 32'(tune_ready), 32'd1);
    chk("rst_pulse", 32'(retune_pulse), 32'd0);

    // reset mid-slew
    @(negedge clk);
    tune_word = 32'h00050000; slew_step = 32'h00020000; tune_valid = 1'b1;
    @(negedge clk);
    tune_valid = 1'b0;
    @(negedge clk);
    chk("midslew_phase", phase_inc, 32'h00020000);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst2_phase_inc", phase_inc, 32'd0);
    chk("rst2_settled", 32'(settled), 32'd1);
    chk("rst2_tune_ready", 32'(tune_ready), 32'd1);
    chk("rst2_pulse", 32'(retune_pulse), 32'd0);

    // direct retune table
    for (int v = 0; v < 7; v++) begin
      @(negedge clk);
      chk("tune_ready_idle", 32'(tune_ready), 32'd1);
      tune_word = vecs[v].word; slew_step = vecs[v].step; tune_valid = 1'b1;
      @(negedge clk);
      tune_valid = 1'b0;
      sb.push_back(vecs[v].word);
      chk("settled_low", 32'(settled), 32'd0);
      chk("tune_ready_slew", 32'(tune_ready), 32'd0);
      n = 0;
      while (!settled && n < 20) begin
        @(negedge clk);
        if (n < 4) obs[n] = phase_inc;
        n++;
      end
      chk("slew_cycles", 32'(n), 32'(vecs[v].ncyc));
      for (int i = 0; i < vecs[v].ncyc && i < 4; i++) chk("slew_trace", obs[i], vecs[v].trace[i]);
      chk("pulse_high", 32'(retune_pulse), 32'd1);
      @(negedge clk);
      chk("pulse_low", 32'(retune_pulse), 32'd0);
    end

    // scan with wrap; tune_valid held high to show it is gated off
    @(negedge clk);
    scan_start = 32'h100; scan_stop = 32'h300; scan_step = 32'h100; dwell = 24'd3; slew_step = 32'd0;
    tune_word = 32'hDEAD0000; tune_valid = 1'b1;
    chan[0] = 32'h100; chan[1] = 32'h200; chan[2] = 32'h300; chan[3] = 32'h100;
    sb.push_back(32'h100); sb.push_back(32'h200); sb.push_back(32'h300);
    sb.push_back(32'h100); sb.push_back(32'h200);
    scan_en = 1'b1;
    @(negedge clk);
    chk("scan_settled_low", 32'(settled), 32'd0);
    chk("scan_ready_low", 32'(tune_ready), 32'd0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("scan_phase", phase_inc, chan[i/4]);
      chk("scan_ready", 32'(tune_ready), 32'd0);
      chk("scan_pulse", 32'(retune_pulse), 32'((i % 4) == 0));
    end
    // now mid-slew toward 0x200: dropping scan_en lets the slew finish then idles
    scan_en = 1'b0; tune_valid = 1'b0;
    @(negedge clk);
    chk("stop_slew_phase", phase_inc, 32'h200);
    chk("stop_slew_pulse", 32'(retune_pulse), 32'd1);
    chk("stop_slew_ready", 32'(tune_ready), 32'd1);
    chk("stop_slew_settled", 32'(settled), 32'd1);

    // hold while on 0x200
    @(negedge clk);
    sb.push_back(32'h100); sb.push_back(32'h200); sb.push_back(32'h300);
    scan_en = 1'b1;
    wait_pulse("hold_reach_200", 32'h200);
    hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_phase", phase_inc, 32'h200);
      chk("hold_settled", 32'(settled), 32'd1);
    end
    hold = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (phase_inc == 32'h200 && n < 30);
    chk("hold_remaining", 32'(n), 32'd4);
    chk("hold_next_phase", phase_inc, 32'h300);
    chk("hold_next_pulse", 32'(retune_pulse), 32'd1);
    // drop scan during DWELL
    scan_en = 1'b0;
    @(negedge clk);
    chk("dwell_stop_ready", 32'(tune_ready), 32'd1);
    chk("dwell_stop_phase", phase_inc, 32'h300);
    chk("dwell_stop_settled", 32'(settled), 32'd1);
    chk("dwell_stop_pulse", 32'(retune_pulse), 32'd0);

    // 33-bit carry wraps back to scan_start
    @(negedge clk);
    scan_start = 32'hFFFFFF00; scan_stop = 32'hFFFFFFFF; scan_step = 32'h200; dwell = 24'd1;
    sb.push_back(32'hFFFFFF00); sb.push_back(32'hFFFFFF00);
    scan_en = 1'b1;
    wait_pulse("carry_first", 32'hFFFFFF00);
    @(negedge clk);
    chk("carry_slew", 32'(settled), 32'd0);
    @(negedge clk);
    chk("carry_phase", phase_inc, 32'hFFFFFF00);
    chk("carry_pulse", 32'(retune_pulse), 32'd1);
    scan_en = 1'b0;
    @(negedge clk);
    chk("carry_stop_ready", 32'(tune_ready), 32'd1);
    chk("carry_stop_pulse", 32'(retune_pulse), 32'd0);

    // scan_step 0 with dwell 0: two-cycle channel period, always on scan_start
    @(negedge clk);
    scan_start = 32'h500; scan_stop = 32'h600; scan_step = 32'd0; dwell = '0;
    repeat (4) sb.push_back(32'h500);
    scan_en = 1'b1;
    wait_pulse("step0_first", 32'h500);
    for (int i = 1; i < 6; i++) begin
      @(negedge clk);
      chk("step0_pulse", 32'(retune_pulse), 32'((i % 2) == 0));
      chk("step0_phase", phase_inc, 32'h500);
    end
    scan_en = 1'b0;
    @(negedge clk);
    chk("step0_stop_pulse", 32'(retune_pulse), 32'd1);
    chk("step0_stop_ready", 32'(tune_ready), 32'd1);

    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/nco_tune_ctrl.md
Name: nco_tune_ctrl

Overview:
- Tuning sequencer that drives the 32-bit phase_inc word of the receiver's phase-accumulator NCO.
- Supports direct retune requests over a valid/ready handshake, with a per-cycle slew limit that prevents large frequency jumps in the mixer.
- Supports an automatic band scan (start/stop/step/dwell) with a hold input from the carrier-detect logic.
- Sits between the control/register interface and the NCO; its phase_inc output connects directly to the NCO phase_inc input.

Parameters:
DWELL_W, 24, width of the dwell counter and dwell input (cycles per scan channel)

Ports:
clk  in  1  system clock; single clock domain
reset  in  1  synchronous, active-high reset
tune_valid  in  1  direct retune request valid
tune_ready  out  1  controller can accept a direct retune
tune_word  in  32  requested target phase increment (unsigned)
slew_step  in  32  max |change| of phase_inc per cycle; 0 = jump immediately
scan_en  in  1  level; 1 = run band scan
scan_start  in  32  first scan channel phase increment
scan_stop  in  32  last scan channel (inclusive upper bound)
scan_step  in  32  channel spacing
dwell  in  DWELL_W  cycles to remain on each scan channel; 0 treated as 1
hold  in  1  freeze scan on current channel (carrier found)
phase_inc  out  32  registered phase increment to NCO
settled  out  1  1 when phase_inc equals latched target and no slew is in progress
retune_pulse  out  1  one-cycle pulse in the cycle after phase_inc reaches a new target

Behaviour:
- Reset (synchronous, reset=1 at a clk edge):
  - phase_inc=0, target=0, state=IDLE.
  - settled=1, retune_pulse=0, tune_ready=1, dwell counter=0.
  - Reset overrides everything, including a slew in progress.
- All arithmetic is 32-bit unsigned; frequency words never wrap during slew.
- States: IDLE, SLEW, DWELL.
- IDLE:
  - tune_ready = ~scan_en.
  - tune_valid & tune_ready at an edge: target<=tune_word, go SLEW.
  - scan_en=1: target<=scan_start, go SLEW (scan mode flag set). tune_valid is ignored.
  - If tune_word equals the current phase_inc, still go SLEW; this produces 1 cycle of settled=0 and a retune_pulse.
- SLEW (settled=0, tune_ready=0), one update per cycle:
  - d = |target - phase_inc|.
  - If slew_step==0 or d<=slew_step: phase_inc<=target; retune_pulse=1 next cycle. Then go to DWELL (counter<=max(dwell,1)) if scan mode, else IDLE.
  - Otherwise: phase_inc <= phase_inc ± slew_step, toward target.
  - slew_step is sampled every cycle; changing it mid-slew takes effect on the next update.
- DWELL (settled=1, tune_ready=0):
  - scan_en=0: go IDLE next cycle; phase_inc retained; scan mode cleared.
  - hold=1: counter frozen; stay.
  - hold=0 and counter>1: counter decrements.
  - hold=0 and counter<=1: compute next = phase_inc + scan_step (33-bit). If the carry is set or next > scan_stop, target<=scan_start; else target<=next. Go SLEW.
- scan_en deasserted during SLEW: the slew completes to its target, then the block goes IDLE (no DWELL).
- Scan timing with slew_step=0: each channel is held for max(dwell,1)+1 cycles (DWELL cycles plus 1 SLEW cycle).
- scan_step=0: the scan stays on scan_start indefinitely, issuing a retune_pulse every channel period.
- scan_start > scan_stop: every step wraps back to scan_start.
- retune_pulse is exactly one cycle wide per completed slew and is never asserted in IDLE or DWELL except in the cycle after a slew completes.

Test Plan:
1. Reset: assert reset for 2 cycles mid-slew (target 0x00050000) -> next cycle phase_inc=0, settled=1, tune_ready=1, retune_pulse=0.
2. Direct jump: slew_step=0, accept tune_word=0x0A3D70A4 at edge k -> phase_inc=0x0A3D70A4 after edge k+1; retune_pulse high for exactly one cycle; settled low for exactly one cycle.
3. Slew limiting:
   - Upward: from 0, target 0x00050000, slew_step 0x00020000 -> phase_inc 0x20000, 0x40000, 0x50000 on successive cycles, then pulse.
   - Downward: retune to 0x00010000 -> 0x30000, 0x10000.
4. Scan with wrap: start 0x100, stop 0x300, step 0x100, dwell 3, slew 0, scan_en=1 -> phase_inc sequence 0x100, 0x200, 0x300, 0x100, each value held 4 cycles; one retune_pulse per channel; tune_ready=0 throughout.
5. Hold: in the configuration of scenario 4, assert hold for 10 cycles while on 0x200 -> phase_inc stays 0x200 for 10+remaining dwell cycles. After release, the scan proceeds to 0x300. Also, 33-bit carry case: start 0xFFFFFF00, stop 0xFFFFFFFF, step 0x200 -> next channel wraps to 0xFFFFFF00.
6. Handshake gating: tune_valid=1 while scan_en=1 -> tune_ready=0 and phase_inc unaffected. Drop scan_en during DWELL -> IDLE next cycle, phase_inc retained, tune_ready=1.
